// File: rtl/shift_writeback_buffer.sv
// Purpose : two-entry registered writeback buffer behind the barrel shifter; stores result, rd and flags.
// Latency : entry accepted at edge k is visible on wb_* right after edge k (when empty or head popped at k).
// Backpress: in_ready = not full (state decode only, no path from wb_ready); wb_* held stable while stalled.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake; in_data, in_amt, in_rd carry the shifter result
//   flush                       synchronous discard of all buffered entries (highest priority)
//   wb_valid/wb_ready           writeback handshake; wb_data, wb_rd, wb_zero, wb_neg, wb_err from the head slot
//   occupancy                   number of valid entries (0..2)
//   stall_cnt                   saturating count of cycles with wb_valid & !wb_ready
module shift_writeback_buffer #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [15:0]       in_amt,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_zero,
    output logic              wb_neg,
    output logic              wb_err,
    output logic [1:0]        occupancy,
    output logic [7:0]        stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              zero;
        logic              neg;
        logic              err;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e       r_occ;
    occ_e       w_occ_nxt;
    entry_t     r_slot0;
    entry_t     r_slot1;
    entry_t     w_slot0_nxt;
    entry_t     w_slot1_nxt;
    entry_t     w_in_entry;
    logic [7:0] r_stall_cnt;
    logic       w_in_ready;
    logic       w_wb_valid;
    logic       w_push;
    logic       w_pop;

    // Flags are captured with the entry so writeback never recomputes them.
    // An amount above 15 means the shifter produced its default of zero.
    always_comb begin
        w_in_entry      = '0;
        w_in_entry.data = in_data;
        w_in_entry.rd   = in_rd;
        w_in_entry.zero = (in_data == '0);
        w_in_entry.neg  = in_data[DATA_W-1];
        w_in_entry.err  = (in_amt > 16'd15);
    end

    assign w_in_ready = (r_occ != OCC_FULL);
    assign w_wb_valid = (r_occ != OCC_EMPTY);
    assign w_push     = in_valid & w_in_ready;
    assign w_pop      = w_wb_valid & wb_ready;

    always_comb begin
        w_occ_nxt   = r_occ;
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        if (flush) begin
            // Slot contents are left as-is; they are simply no longer valid.
            w_occ_nxt = OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_push) begin
                        w_slot0_nxt = w_in_entry;
                        w_occ_nxt   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_push && w_pop) begin
                        // Head leaves and the new entry takes its place: full-rate streaming.
                        w_slot0_nxt = w_in_entry;
                    end else if (w_push) begin
                        w_slot1_nxt = w_in_entry;
                        w_occ_nxt   = OCC_FULL;
                    end else if (w_pop) begin
                        w_occ_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // No push possible here because in_ready is low.
                    if (w_pop) begin
                        w_slot0_nxt = r_slot1;
                        w_occ_nxt   = OCC_ONE;
                    end
                end
                default: w_occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ   <= OCC_EMPTY;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_slot1_nxt;
        end
    end

    // Stall counter is only cleared by reset; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 8'd0;
        end else if (w_wb_valid && !wb_ready && (r_stall_cnt != 8'hFF)) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign wb_valid  = w_wb_valid;
    assign wb_data   = r_slot0.data;
    assign wb_rd     = r_slot0.rd;
    assign wb_zero   = r_slot0.zero;
    assign wb_neg    = r_slot0.neg;
    assign wb_err    = r_slot0.err;
    assign occupancy = r_occ;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_shift_writeback_buffer.sv
// Purpose : scoreboard bench for shift_writeback_buffer with directed and random traffic.
// Latency : driver changes inputs 1ns after each rising edge; monitor samples on the falling edge.
// Backpress: wb_ready driven by the stimulus; the reference queue mirrors buffer acceptance.
module tb_shift_writeback_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_amt;
    logic [3:0]  in_rd;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_zero;
    logic        wb_neg;
    logic        wb_err;
    logic [1:0]  occupancy;
    logic [7:0]  stall_cnt;

    shift_writeback_buffer #(.DATA_W(16), .RD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_rd     (in_rd),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_zero   (wb_zero),
        .wb_neg    (wb_neg),
        .wb_err    (wb_err),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  rd;
        logic        zero;
        logic        neg;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_stall = 0;
    bit   m_accept = 1'b1;   // buffer could accept at the coming edge (snapshot before pop)
    exp_t head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the reference queue, then account for the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("wb_valid", 32'(wb_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
            m_accept = (exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("wb_data", 32'(wb_data), 32'(head.data));
                check("wb_rd",   32'(wb_rd),   32'(head.rd));
                check("wb_zero", 32'(wb_zero), 32'(head.zero));
                check("wb_neg",  32'(wb_neg),  32'(head.neg));
                check("wb_err",  32'(wb_err),  32'(head.err));
                if (wb_ready) begin
                    void'(exp_q.pop_front());
                end else if (exp_stall < 255) begin
                    exp_stall++;
                end
            end
        end
    end

    // One clock of stimulus; the expected entry is queued when the model says it is accepted.
    task automatic drive(input logic vld, input logic [15:0] d, input logic [15:0] a,
                         input logic [3:0] r, input logic rdy, input logic fl);
        exp_t e;
        in_valid = vld;
        in_data  = d;
        in_amt   = a;
        in_rd    = r;
        wb_ready = rdy;
        flush    = fl;
        @(negedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (vld && m_accept) begin
            e.data = d;
            e.rd   = r;
            e.zero = (d == 16'd0);
            e.neg  = (d >= 16'h8000);
            e.err  = (a > 16'd15);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_occ"},   32'(occupancy), 32'd0);
        check({tag, "_vld"},   32'(wb_valid),  32'd0);
        check({tag, "_rdy"},   32'(in_ready),  32'd1);
        check({tag, "_stall"}, 32'(stall_cnt), 32'd0);
        check({tag, "_data"},  32'(wb_data),   32'd0);
        check({tag, "_rd"},    32'(wb_rd),     32'd0);
        check({tag, "_flags"}, 32'({wb_zero, wb_neg, wb_err}), 32'd0);
    endtask

    initial begin
        logic [15:0] rd_d;
        logic [15:0] rd_a;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_rd = '0;
        flush = 1'b0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single push with immediate writeback.
        drive(1, 16'h8001, 16'd1, 4'd3, 1, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);

        // Fill while stalled; the third value must be refused.
        drive(1, 16'h0000, 16'h0010, 4'd5, 0, 0);
        drive(1, 16'h1234, 16'd2, 4'd6, 0, 0);
        drive(1, 16'hFFFF, 16'd3, 4'd7, 0, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 0, 0);
        // Drain in order.
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);

        // Streaming at one entry per cycle.
        for (int v = 1; v <= 8; v++) drive(1, 16'(v), 16'(v), 4'(v), 1, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);

        // Flush while full with a push attempt.
        drive(1, 16'hA5A5, 16'd4, 4'd1, 0, 0);
        drive(1, 16'h5A5A, 16'd20, 4'd2, 0, 0);
        drive(1, 16'hDEAD, 16'd1, 4'd3, 0, 1);
        drive(0, 16'h0, 16'd0, 4'd0, 0, 0);
        // Flush at occupancy 1 with a push: push must be dropped.
        drive(1, 16'h0042, 16'd1, 4'd4, 0, 0);
        drive(1, 16'h0043, 16'd1, 4'd5, 0, 1);
        drive(0, 16'h0, 16'd0, 4'd0, 0, 0);

        // Long stall to saturate the counter.
        drive(1, 16'h7777, 16'd0, 4'd9, 0, 0);
        drive(1, 16'h8888, 16'd0, 4'd10, 0, 0);
        for (int c = 0; c < 300; c++) drive(0, 16'h0, 16'd0, 4'd0, 0, 0);

        // Asynchronous reset while full.
        rst_n = 1'b0;
        exp_q.delete();
        exp_stall = 0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rd_d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rd_d = 16'd0;
            rd_a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 3) != 0), rd_d, rd_a, 4'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);
        drive(0, 16'h0, 16'd0, 4'd0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_writeback_buffer.md
# shift_writeback_buffer

Registered output stage directly downstream of the combinational barrel shifter (rotate-left opcode 4'b0001, rotate-right opcode 4'b0000). It captures the shifter result together with its destination register and status flags into a 2-entry FIFO. It then presents the entries to register-file writeback under a valid/ready handshake. This decouples the combinational shift path from writeback stalls.

## Interface
Parameters:
- DATA_W, 16, result width (matches shifter out_shift)
- RD_W, 4, destination register index width
- Buffer depth is fixed at 2 entries. It is not a parameter.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream result valid this cycle
- in_ready  output  1  buffer can accept an entry
- in_data  input  DATA_W  shifter result (out_shift)
- in_amt  input  16  shift amount operand B, used only for the error flag
- in_rd  input  RD_W  destination register index
- flush  input  1  synchronous discard of all buffered entries
- wb_valid  output  1  head entry valid
- wb_ready  input  1  writeback consumes head entry
- wb_data  output  DATA_W  head result
- wb_rd  output  RD_W  head destination
- wb_zero  output  1  head result == 0
- wb_neg  output  1  head result[DATA_W-1]
- wb_err  output  1  head shift amount > 15, so the result is the shifter default of 0
- occupancy  output  2  number of valid entries, 0..2
- stall_cnt  output  8  saturating count of writeback-stall cycles

## Operation
- Storage: two entries (slot0 = head, slot1 = tail). Each entry holds data, rd, zero, neg and err.
- Flags are computed at push time from the inputs and stored with the entry:
  - zero = (in_data == 0)
  - neg = in_data[DATA_W-1]
  - err = |in_amt[15:4]
- push = in_valid & in_ready. pop = wb_valid & wb_ready.
- in_ready = (occupancy != 2). It is a registered-state decode only, with no combinational path from wb_ready. When full, no push occurs, even if a pop happens in the same cycle.
- wb_valid = (occupancy != 0). The wb_* outputs are driven directly from slot0 registers.
- Next-state by case, with flush taking highest priority:
  - flush=1: occupancy→0 and push is ignored. Stored entries are left unchanged but are not valid. stall_cnt is not affected.
  - occ 0, push: slot0←in, occ→1.
  - occ 1, push only: slot1←in, occ→2.
  - occ 1, pop only: occ→0.
  - occ 1, push & pop: slot0←in, occ stays 1.
  - occ 2, pop: slot0←slot1, occ→1. Push is impossible because in_ready=0.
  - No push and no pop: hold.
- in_valid with in_ready=0 is a no-op. Upstream must hold its data; this block does not latch it.
- stall_cnt increments by 1 on each cycle with wb_valid & !wb_ready. It saturates at 255 and clears only on reset.
- The buffer never reorders entries. Output order equals acceptance order.

## Timing
- Reset (rst_n low, asynchronous): occupancy=0, wb_valid=0, in_ready=1, wb_data=0, wb_rd=0, wb_zero=0, wb_neg=0, wb_err=0, stall_cnt=0. All slot registers are cleared to 0.
- Reset deassertion: the first push can occur at the first rising edge with rst_n high.
- Latency: an entry accepted at edge k appears on wb_* with wb_valid=1 immediately after edge k, provided the buffer was empty or slot0 was popped at the same edge.
- Throughput: one entry per cycle while wb_ready stays high. The occ-1 push & pop path sustains this.
- Hold rule: while wb_valid=1 and wb_ready=0, all wb_* outputs stay stable until the pop edge or a flush.
- Flush: wb_valid=0 and in_ready=1 from the cycle after the flush edge.
- Reset mid-operation: all entries are lost at once, with no writeback of partial state.

## Test plan
- Reset with rst_n=0 mid-stream while occupancy=2 -> next cycle wb_valid=0, in_ready=1, occupancy=0, stall_cnt=0, all wb_* equal 0.
- Single push in_data=16'h8001, in_amt=1, in_rd=3 with wb_ready=1 -> one cycle later wb_valid=1, wb_data=16'h8001, wb_rd=3, wb_neg=1, wb_zero=0, wb_err=0; after the pop, occupancy=0.
- Hold wb_ready=0 and push 16'h0000 (amt=16'h0010), then 16'h1234, then attempt 16'hFFFF -> occupancy=2, in_ready=0, third value not stored; head shows wb_zero=1, wb_err=1; stall_cnt increments every stalled cycle.
- From the full state, assert wb_ready=1 for 2 cycles -> outputs in order 16'h0000 then 16'h1234, then wb_valid=0; no 16'hFFFF ever appears.
- Hold occupancy=1 with continuous in_valid=1 and wb_ready=1 for values 1..8 -> one pop per cycle, outputs 1..8 in order, occupancy stays 1 throughout.
- Assert flush in the same cycle as a push while occupancy=2 -> next cycle occupancy=0, wb_valid=0, pushed entry discarded; hold wb_ready=0 for 300 cycles with data present -> stall_cnt saturates at 255.
